instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Front end of the pipeline and initiator side of the instruction-memory interface. Holds the PC and drives `address` to the combinational `instruction_memory`. Captures the returned `instruction` into the IF/ID pipeline register. Handles start-up, stall, flush, branch/jump redirect and halt detection.

Parameters:
ADDR_W, 32, PC / memory address width
DATA_W, 32, instruction width
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch
NOP_INSTR, 32'h0000_0000, value loaded into IF/ID on a bubble

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
startin  in  ADDR_W  boot address; sampled while rst=1
start  in  1  one-cycle pulse; leaves IDLE
stall  in  1  hazard stall from decode; freezes PC and IF/ID
flush  in  1  squash IF/ID contents
redirect_valid  in  1  branch/jump taken
redirect_pc  in  ADDR_W  target PC
address  out  ADDR_W  to instruction_memory; equals pc register (combinational)
instruction  in  DATA_W  from instruction_memory; valid in the same cycle as address
if_id_instr  out  DATA_W  registered instruction
if_id_pc  out  ADDR_W  PC of if_id_instr
if_id_pc4  out  ADDR_W  if_id_pc + 4
if_id_valid  out  1  IF/ID holds a real instruction
halted  out  1  halt instruction fetched
fetch_count  out  32  count of instructions delivered with if_id_valid=1

Behaviour:
- Reset (rst=1 at an edge):
  - pc <= {startin[ADDR_W-1:2], 2'b00}
  - state <= IDLE
  - if_id_instr <= NOP_INSTR; if_id_pc, if_id_pc4 <= 0
  - if_id_valid, halted <= 0; fetch_count <= 0
  - rst overrides all other inputs, including mid-operation.
- States are IDLE, RUN and HALTED.
- IDLE:
  - PC held; IF/ID holds its bubble.
  - start=1 moves to RUN at that edge. Nothing is captured on that edge.
  - stall, flush and redirect are ignored.
- RUN: per-edge priority, highest first:
  1. redirect_valid: pc <= {redirect_pc[ADDR_W-1:2],2'b00}; IF/ID <= bubble (instr=NOP_INSTR, valid=0). Applies even if stall=1.
  2. flush: IF/ID <= bubble; pc held.
  3. stall: pc and all IF/ID outputs held unchanged.
  4. Normal: if_id_instr <= instruction; if_id_pc <= pc; if_id_pc4 <= pc+4; if_id_valid <= 1; pc <= pc+4.
     - If instruction == HALT_INSTR: pc is held instead of advancing, state <= HALTED, halted <= 1.
     - The halt instruction is still delivered with valid=1 and is counted.
- HALTED:
  - pc frozen; IF/ID <= bubble on every edge.
  - halted stays 1; all inputs except rst are ignored.
  - Exit is by reset only.
- Latency: start seen at edge k. The instruction at startin appears in IF/ID after edge k+1, then one instruction per unstalled cycle.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 wraps to 0. if_id_pc4 wraps the same way.
- fetch_count increments by 1 on each edge that loads if_id_valid=1, and wraps at 2^32.
- address is never misaligned: bits [1:0] are always 0.

Test Plan:
- Boot: rst=1 with startin=32'h0000_0010, then rst=0, start pulse. Memory returns addr-derived words. Response: address follows 10,14,18,1C on successive cycles. if_id_pc goes 10,14,18 with valid=1 starting one edge after start. fetch_count=3 after three fetches.
- Stall: in RUN at pc=8, hold stall=1 for 2 cycles. Response: address stays 8, IF/ID unchanged and valid unchanged. Resumes with if_id_pc=8 the edge after stall drops.
- Redirect with stall: redirect_valid=1, redirect_pc=32'h0000_0043, stall=1 together. Response: next cycle address=32'h40, if_id_valid=0, if_id_instr=0. The following edge gives if_id_pc=32'h40.
- Flush: flush=1 at pc=C. Response: if_id_valid=0, address remains C, fetch_count unchanged.
- Halt: instruction at 32'h14 = 32'hFFFF_FFFF. Response: if_id_instr=FFFF_FFFF with valid=1, halted=1, address frozen at 14. Valid=0 on all following cycles. A redirect afterwards has no effect.
- Wrap and reset mid-run:
  - startin=32'hFFFF_FFFC, then start. Response: if_id_pc4=0 and next address=0.
  - Assert rst during RUN. Response: all outputs return to their reset values at the next edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory
// address and registers the returned word into the IF/ID bundle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   startin           boot address, sampled while rst=1
//   start             one-cycle pulse that begins fetching
//   stall             freezes PC and IF/ID
//   flush             squashes IF/ID to a bubble
//   redirect_valid    taken branch/jump
//   redirect_pc       target of the redirect
//   address           to instruction memory (current PC)
//   instruction       from instruction memory, same cycle as address
//   if_id_instr       registered instruction
//   if_id_pc          PC of if_id_instr
//   if_id_pc4         if_id_pc + 4
//   if_id_valid       IF/ID holds a real instruction
//   halted            a halt instruction has been fetched
//   fetch_count       number of valid instructions delivered
module instruction_fetch #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter logic [DATA_W-1:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] startin,
    input  logic              start,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [ADDR_W-1:0] ipc4_q, ipc4_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic [31:0]       count_q, count_d;

    logic [ADDR_W-1:0] pc_plus4;
    logic              is_halt;

    // PC arithmetic wraps naturally at 2^ADDR_W
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign is_halt  = (instruction == HALT_INSTR);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        ipc4_d   = ipc4_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    // Redirect wins over stall: the target must not be lost
                    pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (flush) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d = instruction;
                    ipc_d   = pc_q;
                    ipc4_d  = pc_plus4;
                    valid_d = 1'b1;
                    count_d = count_q + 32'd1;
                    if (is_halt) begin
                        // Halt is delivered and counted, but PC stops on it
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            HALTED: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= {startin[ADDR_W-1:2], 2'b00};
            instr_q  <= NOP_INSTR;
            ipc_q    <= '0;
            ipc4_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            ipc4_q   <= ipc4_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign address     = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ipc_q;
    assign if_id_pc4   = ipc4_q;
    assign if_id_valid = valid_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios plus randomized
// episodes compared cycle by cycle against a behavioural model.
module tb_instruction_fetch;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, start, stall, flush, redirect_valid;
    logic [31:0] startin, redirect_pc;
    logic [31:0] address, instruction;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc4, fetch_count;
    logic        if_id_valid, halted;
    logic [31:0] halt_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk),
        .rst(rst),
        .startin(startin),
        .start(start),
        .stall(stall),
        .flush(flush),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .address(address),
        .instruction(instruction),
        .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid),
        .halted(halted),
        .fetch_count(fetch_count)
    );

    // Address-derived memory contents; halt word only at halt_addr
    function automatic logic [31:0] hashw(input logic [31:0] a);
        logic [31:0] h;
        h = (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
        if (h == HALT) h = 32'h0000_0001;
        return h;
    endfunction

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == halt_addr) ? HALT : hashw(a);
    endfunction

    assign instruction = (address == halt_addr) ? HALT : hashw(address);

    // Reference model
    int          m_mode;   // 0 idle, 1 running, 2 halted
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
    logic        m_valid, m_halted;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("address", address, m_pc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("fetch_count", fetch_count, m_cnt);
        if (m_valid) begin
            chk("if_id_pc", if_id_pc, m_ipc);
            chk("if_id_pc4", if_id_pc4, m_ipc4);
        end
    endtask

    // Apply one clock edge to both model and DUT, then compare
    task automatic step();
        logic [31:0] w;
        if (rst) begin
            m_mode   = 0;
            m_pc     = startin & ~32'h3;
            m_instr  = NOP;
            m_ipc    = 0;
            m_ipc4   = 0;
            m_valid  = 0;
            m_halted = 0;
            m_cnt    = 0;
        end else if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 2) begin
            m_instr = NOP;
            m_valid = 0;
        end else if (redirect_valid) begin
            m_pc    = redirect_pc & ~32'h3;
            m_instr = NOP;
            m_valid = 0;
        end else if (flush) begin
            m_instr = NOP;
            m_valid = 0;
        end else if (!stall) begin
            w       = mem(m_pc);
            m_instr = w;
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 4;
            m_valid = 1;
            m_cnt   = m_cnt + 1;
            if (w == HALT) begin
                m_mode   = 2;
                m_halted = 1;
            end else begin
                m_pc = m_pc + 4;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_ctl();
        start          = 0;
        stall          = 0;
        flush          = 0;
        redirect_valid = 0;
        redirect_pc    = 0;
    endtask

    task automatic boot(input logic [31:0] sa, input logic [31:0] ha);
        rst       = 1;
        startin   = sa;
        halt_addr = ha;
        clear_ctl();
        step();
        rst = 0;
        start = 1;
        step();
        start = 0;
    endtask

    initial begin
        logic [31:0] c0;
        logic [31:0] sa;
        rst = 1;
        startin = 32'h10;
        halt_addr = 32'h1;
        clear_ctl();

        // Reset and boot at 0x10
        step();
        step();
        chk("rst_addr", address, 32'h10);
        chk("rst_valid", 32'(if_id_valid), 0);
        chk("rst_cnt", fetch_count, 0);
        rst = 0;
        start = 1;
        step();
        start = 0;
        chk("boot_addr0", address, 32'h10);
        chk("boot_valid0", 32'(if_id_valid), 0);
        step();
        chk("boot_pc0", if_id_pc, 32'h10);
        chk("boot_addr1", address, 32'h14);
        step();
        step();
        chk("boot_cnt3", fetch_count, 3);
        chk("boot_pc2", if_id_pc, 32'h18);
        chk("boot_addr3", address, 32'h1C);

        // Stall at pc=8
        boot(32'h0, 32'h1);
        step();
        step();
        chk("stall_pre", address, 32'h8);
        stall = 1;
        step();
        step();
        chk("stall_addr", address, 32'h8);
        chk("stall_pc", if_id_pc, 32'h4);
        chk("stall_valid", 32'(if_id_valid), 1);
        stall = 0;
        step();
        chk("stall_resume", if_id_pc, 32'h8);

        // Redirect together with stall
        redirect_valid = 1;
        redirect_pc = 32'h43;
        stall = 1;
        step();
        clear_ctl();
        chk("redir_addr", address, 32'h40);
        chk("redir_valid", 32'(if_id_valid), 0);
        chk("redir_instr", if_id_instr, 0);
        step();
        chk("redir_pc", if_id_pc, 32'h40);

        // Flush
        c0 = fetch_count;
        flush = 1;
        step();
        flush = 0;
        chk("flush_valid", 32'(if_id_valid), 0);
        chk("flush_addr", address, 32'h44);
        chk("flush_cnt", fetch_count, c0);

        // Halt at 0x14
        boot(32'h10, 32'h14);
        step();
        step();
        chk("halt_instr", if_id_instr, HALT);
        chk("halt_valid", 32'(if_id_valid), 1);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_addr", address, 32'h14);
        step();
        chk("halt_bubble", 32'(if_id_valid), 0);
        redirect_valid = 1;
        redirect_pc = 32'h100;
        step();
        clear_ctl();
        chk("halt_redir", address, 32'h14);
        chk("halt_stay", 32'(halted), 1);

        // Wrap, then reset mid-run
        boot(32'hFFFF_FFFC, 32'h1);
        step();
        chk("wrap_pc4", if_id_pc4, 0);
        chk("wrap_addr", address, 0);
        step();
        rst = 1;
        step();
        chk("mid_rst_addr", address, 32'hFFFF_FFFC);
        chk("mid_rst_valid", 32'(if_id_valid), 0);
        chk("mid_rst_cnt", fetch_count, 0);
        chk("mid_rst_instr", if_id_instr, 0);
        rst = 0;

        // Randomized episodes
        for (int e = 0; e < 30; e++) begin
            if ($urandom_range(0, 3) == 0)
                sa = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                sa = $urandom;
            rst = 1;
            startin = sa;
            if ($urandom_range(0, 1) == 1)
                halt_addr = {sa[31:2], 2'b00} + 32'(4 * $urandom_range(2, 30));
            else
                halt_addr = 32'h1;
            clear_ctl();
            step();
            rst = 0;
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                stall = ($urandom_range(0, 1) == 1);
                flush = ($urandom_range(0, 1) == 1);
                redirect_valid = ($urandom_range(0, 1) == 1);
                redirect_pc = $urandom;
                step();
            end
            clear_ctl();
            start = 1;
            step();
            for (int i = 0; i < 60; i++) begin
                start = ($urandom_range(0, 15) == 0);
                stall = ($urandom_range(0, 3) == 0);
                flush = ($urandom_range(0, 7) == 0);
                redirect_valid = ($urandom_range(0, 9) == 0);
                redirect_pc = ($urandom_range(0, 1) == 1) ? $urandom
                            : sa + 32'($urandom_range(0, 127));
                rst = ($urandom_range(0, 49) == 0);
                step();
            end
            rst = 0;
            clear_ctl();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
